// File: rtl/allgates_vector_checker_pkg.sv
// Shared definitions for the all-gates vector checker: FSM states and the
// bit positions of the fifteen gate outputs on the dut_i bus.
package allgates_vector_checker_pkg;

    localparam int unsigned NUM_OUTS = 15;

    localparam int unsigned BIT_NOT    = 0;
    localparam int unsigned BIT_AND    = 1;
    localparam int unsigned BIT_NAND   = 2;
    localparam int unsigned BIT_ANDNOT = 3;
    localparam int unsigned BIT_OR     = 4;
    localparam int unsigned BIT_NOR    = 5;
    localparam int unsigned BIT_ORNOT  = 6;
    localparam int unsigned BIT_XOR    = 7;
    localparam int unsigned BIT_XNOR   = 8;
    localparam int unsigned BIT_AOI3   = 9;
    localparam int unsigned BIT_OAI3   = 10;
    localparam int unsigned BIT_AOI4   = 11;
    localparam int unsigned BIT_OAI4   = 12;
    localparam int unsigned BIT_MUX    = 13;
    localparam int unsigned BIT_NMUX   = 14;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        FIN    = 3'd4
    } state_t;

endpackage

// File: rtl/allgates_vector_checker_if.sv
// Bundle of the checker's control/status signals and the link to the gate block.
// master = sweep controller plus gate block side, slave = checker side.
interface allgates_vector_checker_if;
    import allgates_vector_checker_pkg::*;

    logic                start;
    logic [3:0]          vec;
    logic [NUM_OUTS-1:0] dut_out;
    logic                busy;
    logic                done;
    logic                pass;
    logic [4:0]          err_count;
    logic [3:0]          first_fail_vec;
    logic [NUM_OUTS-1:0] first_fail_mask;
    logic [2:0]          dbg_state;

    modport master (
        output start, dut_out,
        input  vec, busy, done, pass, err_count, first_fail_vec, first_fail_mask, dbg_state
    );

    modport slave (
        input  start, dut_out,
        output vec, busy, done, pass, err_count, first_fail_vec, first_fail_mask, dbg_state
    );

endinterface

// File: rtl/allgates_golden.sv
// Combinational reference for the gate block: the expected fifteen outputs
// for a 4-bit input vector {d,c,b,a}.
module allgates_golden
    import allgates_vector_checker_pkg::*;
(
    input  logic [3:0]          vec_i,
    output logic [NUM_OUTS-1:0] gold_o
);

    logic a, b, c, d;

    assign a = vec_i[0];
    assign b = vec_i[1];
    assign c = vec_i[2];
    assign d = vec_i[3];

    always_comb begin
        gold_o             = '0;
        gold_o[BIT_NOT]    = ~a;
        gold_o[BIT_AND]    = a & b;
        gold_o[BIT_NAND]   = ~(a & b);
        gold_o[BIT_ANDNOT] = a & ~b;
        gold_o[BIT_OR]     = a | b;
        gold_o[BIT_NOR]    = ~(a | b);
        gold_o[BIT_ORNOT]  = a | ~b;
        gold_o[BIT_XOR]    = a ^ b;
        gold_o[BIT_XNOR]   = ~(a ^ b);
        gold_o[BIT_AOI3]   = ~((a & b) | c);
        gold_o[BIT_OAI3]   = ~((a | b) & c);
        gold_o[BIT_AOI4]   = ~((a & b) | (c & d));
        gold_o[BIT_OAI4]   = ~((a | b) & (c | d));
        gold_o[BIT_MUX]    = c ? b : a;
        gold_o[BIT_NMUX]   = ~(c ? b : a);
    end

endmodule

// File: rtl/allgates_vector_checker.sv
// Sweeps vectors 0..LAST_VEC into a gate block, waits for the outputs to
// settle, and compares them against the golden model, tallying failures.
module allgates_vector_checker
    import allgates_vector_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LAST_VEC      = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [3:0]          vec_o,
    input  logic [NUM_OUTS-1:0] dut_i,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [4:0]          err_count,
    output logic [3:0]          first_fail_vec,
    output logic [NUM_OUTS-1:0] first_fail_mask,
    output logic [2:0]          dbg_state
);

    // Handshake: start is honoured only while busy=0; each accepted start
    // yields exactly one single-cycle done pulse unless reset intervenes.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST        = 4'(LAST_VEC);

    state_t              state_q, state_d;
    logic [3:0]          vec_q, vec_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [4:0]          err_q, err_d;
    logic                pass_q, pass_d;
    logic [3:0]          ffv_q, ffv_d;
    logic [NUM_OUTS-1:0] ffm_q, ffm_d;

    logic [NUM_OUTS-1:0] gold;
    logic [NUM_OUTS-1:0] diff;
    logic                vec_fail;

    allgates_golden u_golden (
        .vec_i  (vec_q),
        .gold_o (gold)
    );

    // Case inequality so that X/Z on dut_i is treated as a failure.
    assign diff     = dut_i ^ gold;
    assign vec_fail = (dut_i !== gold);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pass_d  = pass_q;
        ffv_d   = ffv_q;
        ffm_d   = ffm_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = '0;
                    pass_d  = 1'b0;
                    ffv_d   = '0;
                    ffm_d   = '0;
                    vec_d   = '0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                cnt_d   = SETTLE_LOAD;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                if (vec_fail) begin
                    if (err_q != 5'd31) begin
                        err_d = err_q + 5'd1;
                    end
                    if (err_q == 5'd0) begin
                        ffv_d = vec_q;
                        ffm_d = diff;
                    end
                end
                if (vec_q == LAST) begin
                    state_d = FIN;
                end else begin
                    vec_d   = vec_q + 4'd1;
                    state_d = APPLY;
                end
            end
            FIN: begin
                pass_d  = (err_q == 5'd0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            ffv_q   <= '0;
            ffm_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            ffv_q   <= ffv_d;
            ffm_q   <= ffm_d;
        end
    end

    assign vec_o           = vec_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == FIN);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_fail_vec  = ffv_q;
    assign first_fail_mask = ffm_q;
    assign dbg_state       = state_q;

endmodule

// File: doc/allgates_vector_checker.md
ALLGATES_VECTOR_CHECKER -- requirements
Module: allgates_vector_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, giving the number of clocks the DUT outputs settle after each vector is applied (legal range 1..15).
REQ-002 SHALL have parameter LAST_VEC, default 15, giving the final vector index applied (legal range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a sweep.
REQ-006 SHALL have port vec_o, output, 4 bits: stimulus to the gate block, bits {d,c,b,a} = vec_o[3:0].
REQ-007 SHALL have port dut_i, input, 15 bits: gate-block outputs, bit 0..14 = not, and, nand, andnot, or, nor, ornot, xor, xnor, aoi3, oai3, aoi4, oai4, mux, nmux.
REQ-008 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-010 SHALL have port pass, output, 1 bit: high after a sweep with zero mismatching vectors; held until the next start.
REQ-011 SHALL have port err_count, output, 5 bits: number of vectors with at least one mismatch, saturating at 31.
REQ-012 SHALL have ports first_fail_vec (output, 4 bits) and first_fail_mask (output, 15 bits): vector index and mismatch bitmap of the first failing vector.

Function
REQ-013 SHALL implement FSM states IDLE, APPLY, SETTLE, CHECK, FIN.
REQ-014 IDLE: on start=1, SHALL clear err_count, pass, first_fail_vec, first_fail_mask, set vec_o=0, and go to APPLY.
REQ-015 APPLY: SHALL load the settle counter with SETTLE_CYCLES-1 and go to SETTLE; vec_o is stable from APPLY until CHECK exits.
REQ-016 SETTLE: SHALL decrement the counter each cycle, and go to CHECK in the cycle the counter reads 0.
REQ-017 CHECK: SHALL compare dut_i with the golden value for vec_o, bitwise; any differing bit marks the vector failed.
REQ-018 Golden: not=~a, and=a&b, nand=~(a&b), andnot=a&~b, or=a|b, nor=~(a|b), ornot=a|~b, xor=a^b, xnor=~(a^b), aoi3=~((a&b)|c), oai3=~((a|b)&c), aoi4=~((a&b)|(c&d)), oai4=~((a|b)&(c|d)), mux=c?b:a, nmux=~(c?b:a).
REQ-019 On a failed vector SHALL increment err_count (saturating); on the first failure of the sweep it SHALL capture vec_o and the XOR bitmap.
REQ-020 CHECK: if vec_o==LAST_VEC, SHALL go to FIN; otherwise increment vec_o and go to APPLY.
REQ-021 FIN: SHALL pulse done for exactly one cycle, set pass=(err_count==0, including the final vector's result), and return to IDLE.
REQ-022 busy SHALL be 1 in APPLY, SETTLE, CHECK and FIN, and 0 in IDLE.
REQ-023 start while busy SHALL be ignored.
REQ-024 Per-vector latency SHALL be SETTLE_CYCLES+2 clocks; a full sweep from start to done SHALL take (LAST_VEC+1)*(SETTLE_CYCLES+2)+1 clocks.
REQ-025 X/Z on dut_i SHALL count as a mismatch.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, vec_o=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_mask=0, and a settle counter of 0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; a later start SHALL begin again from vector 0.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the 15 output bit-index constants, and the output count (15).
REQ-029 The golden function SHALL be a combinational sub-module named allgates_golden (4-bit in, 15-bit out), instantiated once.

Verification
REQ-030 Correct gate block wired, start pulse -> done after 65 clocks (defaults), pass=1, err_count=0.
REQ-031 dut_i[7] (xor) forced to 0 -> err_count=8, first_fail_vec=1, first_fail_mask=0x0080, pass=0.
REQ-032 dut_i[13] (mux) inverted -> err_count=16, first_fail_vec=0, first_fail_mask=0x2000.
REQ-033 Reset asserted while vec_o=6 -> next cycle IDLE, all outputs 0, no done; a new start -> vec_o sequence restarts at 0.
REQ-034 start pulsed repeatedly during a sweep -> one done only, sweep length unchanged; SETTLE_CYCLES=1, LAST_VEC=3 -> done after 13 clocks.
